// File: rtl/arith_pkg.sv
// Shared constants, state encoding and sizing helper for the sequential
// arithmetic blocks.
package arith_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for N = width/slice slices; a single slice still needs one bit.
  function automatic int cnt_width(input int width, input int slice);
    int n;
    n = width / slice;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit carry-look-ahead adder: every carry is a flat
// sum-of-products over generate/propagate terms and the carry-in.
module cla_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   pz;
  logic [W:0]   c;

  assign g  = a & b;
  assign p  = a ^ b;
  assign pz = {1'b0, p};

  // Mask with bits lo..hi set; empty when lo > hi.
  function automatic logic [W:0] span(input int lo, input int hi);
    logic [W:0] one;
    one = {{W{1'b0}}, 1'b1};
    return (one << (hi + 1)) - (one << lo);
  endfunction

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      c[i+1] = cin & ((pz & span(0, i)) == span(0, i));
      for (int j = 0; j <= i; j++) begin
        c[i+1] = c[i+1] | (g[j] & ((pz & span(j + 1, i)) == span(j + 1, i)));
      end
    end
  end

  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/cla_sequential_subtractor.sv
// Multi-cycle subtractor: resolves a - b - bin one CLA slice per clock,
// LSB first, with the borrow carried between cycles in a register.
module cla_sequential_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = cnt_width(WIDTH, SLICE);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_width_check
      $error("cla_sequential_subtractor: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b_inv;
  logic [SLICE-1:0] sl_sum;
  logic             sl_cout;

  // Subtraction as a + ~b + ~borrow; the slice carry-out is the inverted borrow.
  assign sl_a     = a_q[int'(cnt_q) * SLICE +: SLICE];
  assign sl_b_inv = ~b_q[int'(cnt_q) * SLICE +: SLICE];

  cla_slice #(.W(SLICE)) u_slice (
    .a    (sl_a),
    .b    (sl_b_inv),
    .cin  (~brw_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    work_d  = work_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    busy_d  = (state_q == RUN);
    done_d  = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          work_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[int'(cnt_q) * SLICE +: SLICE] = sl_sum;
        brw_d = ~sl_cout;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        diff_d  = work_q;
        bout_d  = brw_q;
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_q[WIDTH-1] != a_q[WIDTH-1]);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      work_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      work_q  <= work_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
